// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared defaults, FSM state type and address-width helper for cpu_mem_unit
package cpu_mem_pkg;
  localparam int DATA_WIDTH_DEF = 24;
  typedef enum logic {CLEAR, READY} state_t;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/cpu_mem_unit_if.sv
// cpu_mem_unit_if: fetch, program-load, data-access and clear signals of cpu_mem_unit
interface cpu_mem_unit_if #(
  parameter int DATA_WIDTH = 24,
  parameter int INSTR_AW = 15,
  parameter int DATA_AW = 16
);
  logic                  if_req;
  logic [INSTR_AW-1:0]   if_addr;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_data;
  logic                  pl_we;
  logic [INSTR_AW-1:0]   pl_addr;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_AW-1:0]    dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ready;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_fault;
  logic                  clr_req;
  logic                  busy;
  modport master (
    output if_req, if_addr, pl_we, pl_addr, pl_data,
    output dm_req, dm_we, dm_addr, dm_wdata, clr_req,
    input  if_valid, if_data, dm_ready, dm_rvalid, dm_rdata, dm_fault, busy
  );
  modport slave (
    input  if_req, if_addr, pl_we, pl_addr, pl_data,
    input  dm_req, dm_we, dm_addr, dm_wdata, clr_req,
    output if_valid, if_data, dm_ready, dm_rvalid, dm_rdata, dm_fault, busy
  );
endinterface

// File: rtl/sync_ram.sv
// sync_ram: single write port, registered read-first read port, no reset on contents
module sync_ram import cpu_mem_pkg::*; #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int AW = addr_w(DEPTH)
)(
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpu_mem_unit.sv
// cpu_mem_unit: instruction/data memory with program-load port, clear sequencer and faulting data port
module cpu_mem_unit import cpu_mem_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int INSTR_DEPTH = 32768,
  parameter int DATA_DEPTH = 16384,
  parameter int DATA_AW = 16
)(
  input logic mem_clk,
  input logic mem_rst_n,
  cpu_mem_unit_if.slave bus
);
  localparam int RAW = addr_w(DATA_DEPTH);
  localparam logic [DATA_AW:0] LIM = (DATA_AW+1)'(DATA_DEPTH);
  localparam logic [RAW-1:0] LAST = RAW'(DATA_DEPTH-1);
  state_t st;
  logic [RAW-1:0] cnt, d_waddr;
  logic [DATA_WIDTH-1:0] iq, dq, d_wdata;
  logic oor, accept, d_we, d_re, clearing;
  logic if_valid, dm_rvalid, dm_fault, ld_q, busy, dm_ready;
  assign clearing = st == CLEAR;
  assign oor = {1'b0, bus.dm_addr} >= LIM;
  assign accept = bus.dm_req & dm_ready & mem_rst_n;
  assign d_we = clearing | (accept & bus.dm_we & ~oor);
  assign d_re = accept & ~bus.dm_we & ~oor;
  assign d_waddr = clearing ? cnt : bus.dm_addr[RAW-1:0];
  assign d_wdata = clearing ? '0 : bus.dm_wdata;
  sync_ram #(.WIDTH(DATA_WIDTH), .DEPTH(INSTR_DEPTH)) imem (
    .clk(mem_clk), .we(bus.pl_we), .waddr(bus.pl_addr), .wdata(bus.pl_data),
    .re(bus.if_req), .raddr(bus.if_addr), .rdata(iq)
  );
  sync_ram #(.WIDTH(DATA_WIDTH), .DEPTH(DATA_DEPTH)) dmem (
    .clk(mem_clk), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
    .re(d_re), .raddr(bus.dm_addr[RAW-1:0]), .rdata(dq)
  );
  always_ff @(posedge mem_clk) begin
    if (!mem_rst_n) begin
      st        <= CLEAR;
      cnt       <= '0;
      busy      <= 1'b1;
      dm_ready  <= 1'b0;
      if_valid  <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_fault  <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      if_valid  <= bus.if_req;
      dm_rvalid <= accept;
      dm_fault  <= accept & oor;
      ld_q      <= d_re;
      case (st)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            st       <= READY;
            busy     <= 1'b0;
            dm_ready <= 1'b1;
          end
        end
        READY: if (bus.clr_req) begin
          st       <= CLEAR;
          cnt      <= '0;
          busy     <= 1'b1;
          dm_ready <= 1'b0;
        end
      endcase
    end
  end
  // RAM read registers are unreset, so outputs are zeroed unless a valid read is presented
  assign bus.if_valid  = if_valid;
  assign bus.if_data   = if_valid ? iq : '0;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.dm_rdata  = ld_q ? dq : '0;
  assign bus.dm_fault  = dm_fault;
  assign bus.dm_ready  = dm_ready;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_cpu_mem_unit.sv
// tb_cpu_mem_unit: directed self-checking bench for cpu_mem_unit with a 16-word data memory
module tb_cpu_mem_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  cpu_mem_unit_if #(.DATA_WIDTH(24), .INSTR_AW(6), .DATA_AW(5)) bus ();
  cpu_mem_unit #(.DATA_WIDTH(24), .INSTR_DEPTH(64), .DATA_DEPTH(16), .DATA_AW(5)) dut (
    .mem_clk(clk), .mem_rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic dm(input logic we, input logic [4:0] a, input logic [23:0] d);
    bus.dm_req = 1'b1;
    bus.dm_we = we;
    bus.dm_addr = a;
    bus.dm_wdata = d;
    tick;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
  endtask
  task automatic count_busy(output int c);
    c = 0;
    while (bus.busy === 1'b1 && c < 100) begin
      tick;
      c++;
    end
  endtask
  task automatic chk_load(input string tag, input logic [4:0] a, input logic [23:0] exp);
    dm(1'b0, a, 24'h0);
    chk({tag, "_rvalid"}, {31'b0, bus.dm_rvalid}, 1);
    chk({tag, "_rdata"}, {8'b0, bus.dm_rdata}, {8'b0, exp});
    chk({tag, "_fault"}, {31'b0, bus.dm_fault}, 0);
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.pl_we = 0; bus.pl_addr = 0; bus.pl_data = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.clr_req = 0;
    repeat (3) tick;
    chk("rst_if_valid", {31'b0, bus.if_valid}, 0);
    chk("rst_if_data", {8'b0, bus.if_data}, 0);
    chk("rst_dm_rvalid", {31'b0, bus.dm_rvalid}, 0);
    chk("rst_dm_rdata", {8'b0, bus.dm_rdata}, 0);
    chk("rst_dm_fault", {31'b0, bus.dm_fault}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 1);
    chk("rst_dm_ready", {31'b0, bus.dm_ready}, 0);
    rst_n = 1'b1;
    count_busy(n);
    chk("init_clear_cycles", n, 16);
    chk("init_ready", {31'b0, bus.dm_ready}, 1);
    chk_load("clr_ld0", 5'd0, 24'h0);
    chk_load("clr_ld15", 5'd15, 24'h0);
    chk_load("clr_ld7", 5'd7, 24'h0);
    tick;
    chk("rvalid_pulse", {31'b0, bus.dm_rvalid}, 0);
    dm(1'b1, 5'd10, 24'hABCDEF);
    chk("st_rvalid", {31'b0, bus.dm_rvalid}, 1);
    chk("st_rdata", {8'b0, bus.dm_rdata}, 0);
    chk_load("ld10", 5'd10, 24'hABCDEF);
    dm(1'b0, 5'd20, 24'h0);
    chk("flt20_rvalid", {31'b0, bus.dm_rvalid}, 1);
    chk("flt20_fault", {31'b0, bus.dm_fault}, 1);
    chk("flt20_rdata", {8'b0, bus.dm_rdata}, 0);
    dm(1'b1, 5'd26, 24'h555555);
    chk("flt26_fault", {31'b0, bus.dm_fault}, 1);
    dm(1'b0, 5'd16, 24'h0);
    chk("flt16_fault", {31'b0, bus.dm_fault}, 1);
    chk_load("ld10_after_fault", 5'd10, 24'hABCDEF);
    bus.pl_we = 1'b1; bus.pl_addr = 0; bus.pl_data = 24'hA00011;
    tick;
    bus.pl_we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 0;
    tick;
    chk("fetch_valid", {31'b0, bus.if_valid}, 1);
    chk("fetch_data", {8'b0, bus.if_data}, 32'hA00011);
    bus.pl_we = 1'b1; bus.pl_data = 24'h123456;
    tick;
    bus.pl_we = 1'b0;
    chk("fetch_read_first", {8'b0, bus.if_data}, 32'hA00011);
    bus.if_req = 1'b0;
    tick;
    chk("fetch_idle_valid", {31'b0, bus.if_valid}, 0);
    chk("fetch_idle_data", {8'b0, bus.if_data}, 0);
    dm(1'b1, 5'd2, 24'd7);
    bus.clr_req = 1'b1;
    dm(1'b0, 5'd2, 24'h0);
    bus.clr_req = 1'b0;
    chk("clr_same_cycle_ld", {8'b0, bus.dm_rdata}, 7);
    chk("clr_ready_low", {31'b0, bus.dm_ready}, 0);
    bus.if_req = 1'b1; bus.if_addr = 0;
    bus.dm_req = 1'b1; bus.dm_addr = 5'd3;
    n = 0;
    while (bus.dm_ready !== 1'b1 && n < 100) begin
      tick;
      n++;
      if (n == 4) chk("fetch_during_clear", {8'b0, bus.if_data}, 32'h123456);
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    chk("reclear_cycles", n, 16);
    chk("no_accept_in_clear", {31'b0, bus.dm_rvalid}, 0);
    chk_load("reclear_ld2", 5'd2, 24'h0);
    dm(1'b1, 5'd5, 24'h111111);
    bus.clr_req = 1'b1;
    tick;
    bus.clr_req = 1'b0;
    repeat (8) tick;
    rst_n = 1'b0;
    tick;
    chk("midrst_busy", {31'b0, bus.busy}, 1);
    rst_n = 1'b1;
    count_busy(n);
    chk("midrst_clear_cycles", n, 16);
    chk_load("midrst_ld5", 5'd5, 24'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
